// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter: transfer types, responses, master IDs.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  // SEQ and BUSY both mean the owner is mid-burst and must keep the bus.
  function automatic logic burst_cont(input logic [1:0] trans);
    return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahblite_arb_grant.sv
// Combinational grant decision for the two-master arbiter.
// Build option AHB_ARB_ROUND_ROBIN_EN alternates grants on contention; default is fixed M0 priority.
module ahblite_arb_grant
  import ahb_pkg::*;
(
  input  logic [1:0] m0_htrans_i,
  input  logic [1:0] m1_htrans_i,
  input  logic       last_owner_i,
  output logic       grant_o
);

  logic       req0_s;
  logic       req1_s;
  logic [1:0] owner_trans_s;

  // Burst lock first, then single requester, then contention, else park.
  always_comb begin
    req0_s        = m0_htrans_i[1];
    req1_s        = m1_htrans_i[1];
    owner_trans_s = (last_owner_i == MASTER_M1) ? m1_htrans_i : m0_htrans_i;
    grant_o       = last_owner_i;
    if (burst_cont(owner_trans_s)) begin
      grant_o = last_owner_i;
    end else if (req0_s && !req1_s) begin
      grant_o = MASTER_M0;
    end else if (req1_s && !req0_s) begin
      grant_o = MASTER_M1;
    end else if (req0_s && req1_s) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
      grant_o = ~last_owner_i;
`else
      grant_o = MASTER_M0;
`endif
    end else begin
      grant_o = last_owner_i;
    end
  end

endmodule

// File: rtl/ahblite_master_arbiter.sv
// Two-master AHB-Lite arbiter: zero-latency address-phase grant plus data-phase return routing.
// Optional build macro AHB_ARB_ROUND_ROBIN_EN selects round-robin contention (see ahblite_arb_grant).
module ahblite_master_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [1:0]        M0_HTRANS,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic              M0_HREADY,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HRESP,
  input  logic [1:0]        M1_HTRANS,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M1_HREADY,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HRESP,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              HMASTER
);

  logic last_owner_q, last_owner_d;
  logic dp_owner_q, dp_owner_d;
  logic dp_valid_q, dp_valid_d;
  logic arb_grant_s;
  logic grant_s;
  logic resp_s;

  ahblite_arb_grant u_grant (
    .m0_htrans_i (M0_HTRANS),
    .m1_htrans_i (M1_HTRANS),
    .last_owner_i(last_owner_q),
    .grant_o     (arb_grant_s)
  );

  // Ownership may only move on an accepted cycle; a stalled bus keeps the current owner.
  always_comb begin
    grant_s = last_owner_q;
    if (HREADY) begin
      grant_s = arb_grant_s;
    end else begin
      grant_s = last_owner_q;
    end
  end

  // Address/control follow the grant; write data follows the data-phase owner.
  always_comb begin
    HMASTER = grant_s;
    if (grant_s == MASTER_M1) begin
      HTRANS = M1_HTRANS;
      HADDR  = M1_HADDR;
      HWRITE = M1_HWRITE;
      HSIZE  = M1_HSIZE;
    end else begin
      HTRANS = M0_HTRANS;
      HADDR  = M0_HADDR;
      HWRITE = M0_HWRITE;
      HSIZE  = M0_HSIZE;
    end
    if (dp_owner_q == MASTER_M1) begin
      HWDATA = M1_HWDATA;
    end else begin
      HWDATA = M0_HWDATA;
    end
  end

  // A requester that lost arbitration is stalled so it holds its address phase.
  always_comb begin
    resp_s    = (dp_valid_q && (HRESP == HRESP_ERROR)) ? HRESP_ERROR : HRESP_OKAY;
    M0_HRDATA = HRDATA;
    M1_HRDATA = HRDATA;
    if ((grant_s != MASTER_M0) && M0_HTRANS[1]) begin
      M0_HREADY = 1'b0;
    end else begin
      M0_HREADY = HREADY;
    end
    if ((grant_s != MASTER_M1) && M1_HTRANS[1]) begin
      M1_HREADY = 1'b0;
    end else begin
      M1_HREADY = HREADY;
    end
    if (dp_owner_q == MASTER_M1) begin
      M0_HRESP = HRESP_OKAY;
      M1_HRESP = resp_s;
    end else begin
      M0_HRESP = resp_s;
      M1_HRESP = HRESP_OKAY;
    end
  end

  // Next-state: the granted address phase becomes the data phase on an accepted cycle.
  always_comb begin
    last_owner_d = last_owner_q;
    dp_owner_d   = dp_owner_q;
    dp_valid_d   = dp_valid_q;
    if (HREADY) begin
      last_owner_d = grant_s;
      dp_owner_d   = grant_s;
      dp_valid_d   = HTRANS[1];
    end else begin
      last_owner_d = last_owner_q;
      dp_owner_d   = dp_owner_q;
      dp_valid_d   = dp_valid_q;
    end
  end

  // Ownership state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_owner_q <= MASTER_M0;
      dp_owner_q   <= MASTER_M0;
      dp_valid_q   <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      dp_owner_q   <= dp_owner_d;
      dp_valid_q   <= dp_valid_d;
    end
  end

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// Scoreboard bench for ahblite_master_arbiter: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares them.
module tb_ahblite_master_arbiter;
  import ahb_pkg::*;

  localparam logic [1:0] ID = HTRANS_IDLE;
  localparam logic [1:0] BZ = HTRANS_BUSY;
  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] SQ = HTRANS_SEQ;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        M0_HRESP, M1_HRESP;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        HMASTER;

  typedef struct {
    int          n;
    logic        hm;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        r0;
    logic        r1;
    logic        p0;
    logic        p1;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step_no = 0;

  ahblite_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HMASTER(HMASTER)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of master and slave inputs and queue what the arbiter must show for it.
  task automatic step(input logic [1:0] t0, input logic [1:0] t1, input logic hr, input logic rsp,
                      input logic e_hm, input logic e_wd, input logic e_r0, input logic e_r1,
                      input logic e_p0, input logic e_p1);
    exp_t e;
    @(posedge HCLK);
    #1;
    M0_HTRANS = t0;
    M1_HTRANS = t1;
    M0_HADDR  = 32'h2000_0000 + 32'(step_no) * 32'd4;
    M1_HADDR  = 32'h4000_0000 + 32'(step_no) * 32'd4;
    M0_HWDATA = 32'hD0D0_0000 + 32'(step_no);
    M1_HWDATA = 32'hD1D1_0000 + 32'(step_no);
    HREADY    = hr;
    HRESP     = rsp;
    HRDATA    = 32'hCAFE_0000 + 32'(step_no);
    e.n     = step_no;
    e.hm    = e_hm;
    e.trans = e_hm ? t1 : t0;
    e.addr  = e_hm ? M1_HADDR : M0_HADDR;
    e.wr    = e_hm ? 1'b0 : 1'b1;
    e.sz    = e_hm ? 3'b001 : 3'b010;
    e.wd    = e_wd ? M1_HWDATA : M0_HWDATA;
    e.r0    = e_r0;
    e.r1    = e_r1;
    e.p0    = e_p0;
    e.p1    = e_p1;
    e.rd    = HRDATA;
    sb_q.push_back(e);
    step_no++;
  endtask

  // Monitor: compare settled outputs mid-cycle against the oldest queued expectation.
  always @(negedge HCLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq($sformatf("s%0d_hmaster", e.n), 32'(HMASTER), 32'(e.hm));
      check_eq($sformatf("s%0d_htrans", e.n), 32'(HTRANS), 32'(e.trans));
      check_eq($sformatf("s%0d_haddr", e.n), HADDR, e.addr);
      check_eq($sformatf("s%0d_hwrite", e.n), 32'(HWRITE), 32'(e.wr));
      check_eq($sformatf("s%0d_hsize", e.n), 32'(HSIZE), 32'(e.sz));
      check_eq($sformatf("s%0d_hwdata", e.n), HWDATA, e.wd);
      check_eq($sformatf("s%0d_m0_hready", e.n), 32'(M0_HREADY), 32'(e.r0));
      check_eq($sformatf("s%0d_m1_hready", e.n), 32'(M1_HREADY), 32'(e.r1));
      check_eq($sformatf("s%0d_m0_hresp", e.n), 32'(M0_HRESP), 32'(e.p0));
      check_eq($sformatf("s%0d_m1_hresp", e.n), 32'(M1_HRESP), 32'(e.p1));
      check_eq($sformatf("s%0d_m0_hrdata", e.n), M0_HRDATA, e.rd);
      check_eq($sformatf("s%0d_m1_hrdata", e.n), M1_HRDATA, e.rd);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    HRESETn   = 1'b0;
    M0_HTRANS = ID;          M1_HTRANS = ID;
    M0_HADDR  = 32'h0;       M1_HADDR  = 32'h0;
    M0_HWRITE = 1'b1;        M1_HWRITE = 1'b0;
    M0_HSIZE  = 3'b010;      M1_HSIZE  = 3'b001;
    M0_HWDATA = 32'h0;       M1_HWDATA = 32'h0;
    HREADY    = 1'b1;        HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0;

    // Reset state: parked on M0, idle.
    step(ID, ID, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ID, ID, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 HRESETn = 1'b1;

    // Single master M0, then its data phase.
    step(NS, ID, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ID, ID, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // M1 single, then contention (M0 wins in both builds since M1 owned last), M1 switches in.
    step(ID, NS, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(NS, NS, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ID, NS, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // M1 burst NONSEQ, SEQ, BUSY, SEQ, SEQ while M0 waits; M0 in as the burst ends.
    step(ID, NS, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(NS, SQ, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(NS, BZ, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(NS, SQ, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(NS, SQ, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(NS, ID, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Three wait states in M0 data phase: grant frozen, M1 stalled, HWDATA stays M0.
    step(ID, NS, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ID, NS, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ID, NS, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ID, NS, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Two-cycle ERROR to M1, M0 granted on the second cycle.
    step(NS, ID, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(NS, ID, 1'b1, 1'b1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    // Two-cycle ERROR to M0.
    step(ID, ID, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(ID, ID, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Back-to-back singles from both masters for 8 cycles.
    for (int k = 0; k < 8; k++) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
      step(NS, NS, 1'b1, 1'b0,  ~k[0], k[0], k[0], ~k[0], 1'b0, 1'b0);
`else
      step(NS, NS, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    end

    // Reset in the middle of an M1 burst returns everything to M0 idle.
    step(ID, NS, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(ID, SQ, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge HCLK);
    #1 HRESETn = 1'b0;
    step(ID, ID, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 HRESETn = 1'b1;
    step(ID, ID, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    @(negedge HCLK);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
